// File: rtl/vend_front_panel_if.sv
// Request/response bus between the front-panel sequencer and the vending core.
// master: front panel drives mode and request data, samples red_light and change.
// slave:  vending core sees the request, drives red_light and updated_customer_money.
interface vend_front_panel_if;
    logic [1:0] mode;                    // 00 customer, 01 withdraw, 10 supply, 11 idle
    logic [3:0] customer_money;
    logic [2:0] customer_request;
    logic [3:0] quantity_request;
    logic [2:0] product_id;
    logic [3:0] amount_added;
    logic       red_light;               // core error response
    logic [3:0] updated_customer_money;  // core change response

    modport master (
        output mode, customer_money, customer_request, quantity_request,
               product_id, amount_added,
        input  red_light, updated_customer_money
    );

    modport slave (
        input  mode, customer_money, customer_request, quantity_request,
               product_id, amount_added,
        output red_light, updated_customer_money
    );
endinterface

// File: rtl/vend_front_panel.sv
// Front-panel sequencer: accumulates coin credit, issues one-cycle core requests, returns change.
// Latency: request on bus 1 cycle after acceptance, change pulse RESP_LAT+2 cycles after acceptance.
// Backpressure: none; commands outside IDLE are dropped and coins outside IDLE are rejected.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   coin_in/coin_value       : coin insert pulse and value
//   sel_valid/sel_product/sel_qty : customer selection pulse
//   cancel                   : refund request pulse
//   svc_withdraw, svc_supply/svc_product/svc_amount : service commands
//   core                     : request/response bus to the vending core (master side)
//   credit                   : accumulated credit
//   change_valid/change_amount : one-cycle change return
//   coin_reject              : coin returned unaccepted
//   busy, error              : transaction in flight, sticky error
module vend_front_panel #(
    parameter int RESP_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_in,
    input  logic [3:0] coin_value,
    input  logic       sel_valid,
    input  logic [2:0] sel_product,
    input  logic [3:0] sel_qty,
    input  logic       cancel,
    input  logic       svc_withdraw,
    input  logic       svc_supply,
    input  logic [2:0] svc_product,
    input  logic [3:0] svc_amount,
    vend_front_panel_if.master core,
    output logic [3:0] credit,
    output logic       change_valid,
    output logic [3:0] change_amount,
    output logic       coin_reject,
    output logic       busy,
    output logic       error
);

    localparam logic [1:0] MODE_CUST   = 2'b00;
    localparam logic [1:0] MODE_WD     = 2'b01;
    localparam logic [1:0] MODE_SUPPLY = 2'b10;
    localparam logic [1:0] MODE_IDLE   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    state_t state, state_d;

    // Registered core-bus outputs
    logic [1:0] mode_q, mode_d;
    logic [3:0] cust_money_q, cust_money_d;
    logic [2:0] cust_req_q, cust_req_d;
    logic [3:0] qty_req_q, qty_req_d;
    logic [2:0] prod_id_q, prod_id_d;
    logic [3:0] amt_added_q, amt_added_d;

    // Transaction bookkeeping
    logic [1:0] txn_mode, txn_mode_d;    // mode of the transaction in flight
    logic [2:0] wait_cnt, wait_cnt_d;    // WAIT cycles remaining minus one

    // Next values of the panel-side outputs
    logic [3:0] credit_d;
    logic       change_valid_d;
    logic [3:0] change_amount_d;
    logic       coin_reject_d;
    logic       busy_d;
    logic       error_d;

    assign core.mode             = mode_q;
    assign core.customer_money   = cust_money_q;
    assign core.customer_request = cust_req_q;
    assign core.quantity_request = qty_req_q;
    assign core.product_id       = prod_id_q;
    assign core.amount_added     = amt_added_q;

    // Coin accumulation with saturation at 15; commands in the same cycle see this value.
    logic [4:0] coin_sum;
    logic [3:0] credit_post;
    assign coin_sum    = {1'b0, credit} + {1'b0, coin_value};
    assign credit_post = coin_in ? (coin_sum[4] ? 4'hF : coin_sum[3:0]) : credit;

    // Fixed priority: withdraw > supply > cancel > selection; only the winner is considered.
    logic cmd_wd, cmd_sup, cmd_can, cmd_sel, sel_ok;
    logic accept_issue, accept_cancel;
    assign cmd_wd        = svc_withdraw;
    assign cmd_sup       = svc_supply & ~svc_withdraw;
    assign cmd_can       = cancel & ~svc_withdraw & ~svc_supply;
    assign cmd_sel       = sel_valid & ~svc_withdraw & ~svc_supply & ~cancel;
    assign sel_ok        = (credit_post != 4'd0) && (sel_qty != 4'd0);
    assign accept_issue  = cmd_wd | cmd_sup | (cmd_sel & sel_ok);
    assign accept_cancel = cmd_can & (credit_post != 4'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (accept_issue) begin
                    state_d = S_ISSUE;
                end else if (accept_cancel) begin
                    state_d = S_CHANGE;
                end
            end
            S_ISSUE:  state_d = S_WAIT;
            S_WAIT: begin
                if (wait_cnt == 3'd0) begin
                    // Service transactions return no change
                    state_d = (txn_mode == MODE_CUST) ? S_CHANGE : S_IDLE;
                end
            end
            S_CHANGE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: next values for every registered output
    always_comb begin
        mode_d          = MODE_IDLE;
        cust_money_d    = cust_money_q;
        cust_req_d      = cust_req_q;
        qty_req_d       = qty_req_q;
        prod_id_d       = prod_id_q;
        amt_added_d     = amt_added_q;
        txn_mode_d      = txn_mode;
        wait_cnt_d      = wait_cnt;
        credit_d        = credit;
        change_valid_d  = 1'b0;
        change_amount_d = change_amount;
        coin_reject_d   = coin_in && (state != S_IDLE);
        busy_d          = (state_d != S_IDLE);
        error_d         = error;

        case (state)
            S_IDLE: begin
                credit_d = credit_post;
                if (cmd_wd) begin
                    error_d    = 1'b0;
                    txn_mode_d = MODE_WD;
                    mode_d     = MODE_WD;
                end else if (cmd_sup) begin
                    error_d     = 1'b0;
                    txn_mode_d  = MODE_SUPPLY;
                    mode_d      = MODE_SUPPLY;
                    prod_id_d   = svc_product;
                    amt_added_d = svc_amount;
                end else if (cmd_can) begin
                    if (accept_cancel) begin
                        change_valid_d  = 1'b1;
                        change_amount_d = credit_post;
                        credit_d        = 4'd0;
                    end
                end else if (cmd_sel) begin
                    if (sel_ok) begin
                        error_d      = 1'b0;
                        txn_mode_d   = MODE_CUST;
                        mode_d       = MODE_CUST;
                        cust_money_d = credit_post;
                        cust_req_d   = sel_product;
                        qty_req_d    = sel_qty;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                wait_cnt_d = 3'(RESP_LAT - 1);
            end
            S_WAIT: begin
                if (wait_cnt == 3'd0) begin
                    if (core.red_light) begin
                        error_d = 1'b1;
                    end
                    if (txn_mode == MODE_CUST) begin
                        // Core error refunds the full credit instead of the core's change
                        change_valid_d  = 1'b1;
                        change_amount_d = core.red_light ? credit : core.updated_customer_money;
                        credit_d        = 4'd0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt - 3'd1;
                end
            end
            S_CHANGE: begin
            end
            default: begin
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q        <= MODE_IDLE;
            cust_money_q  <= 4'd0;
            cust_req_q    <= 3'd0;
            qty_req_q     <= 4'd0;
            prod_id_q     <= 3'd0;
            amt_added_q   <= 4'd0;
            txn_mode      <= MODE_IDLE;
            wait_cnt      <= 3'd0;
            credit        <= 4'd0;
            change_valid  <= 1'b0;
            change_amount <= 4'd0;
            coin_reject   <= 1'b0;
            busy          <= 1'b0;
            error         <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            cust_money_q  <= cust_money_d;
            cust_req_q    <= cust_req_d;
            qty_req_q     <= qty_req_d;
            prod_id_q     <= prod_id_d;
            amt_added_q   <= amt_added_d;
            txn_mode      <= txn_mode_d;
            wait_cnt      <= wait_cnt_d;
            credit        <= credit_d;
            change_valid  <= change_valid_d;
            change_amount <= change_amount_d;
            coin_reject   <= coin_reject_d;
            busy          <= busy_d;
            error         <= error_d;
        end
    end

endmodule

// File: tb/tb_vend_front_panel.sv
// Self-checking bench for vend_front_panel: directed panel stimulus, expected bus
// issues and change pulses queued with their cycle numbers, popped by a monitor.
module tb_vend_front_panel;
    localparam int RL = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_in = 1'b0;
    logic [3:0] coin_value = 4'd0;
    logic       sel_valid = 1'b0;
    logic [2:0] sel_product = 3'd0;
    logic [3:0] sel_qty = 4'd0;
    logic       cancel = 1'b0;
    logic       svc_withdraw = 1'b0;
    logic       svc_supply = 1'b0;
    logic [2:0] svc_product = 3'd0;
    logic [3:0] svc_amount = 4'd0;
    logic [3:0] credit;
    logic       change_valid;
    logic [3:0] change_amount;
    logic       coin_reject;
    logic       busy;
    logic       error;

    vend_front_panel_if bus ();

    vend_front_panel #(.RESP_LAT(RL)) dut (
        .clk(clk), .rst(rst),
        .coin_in(coin_in), .coin_value(coin_value),
        .sel_valid(sel_valid), .sel_product(sel_product), .sel_qty(sel_qty),
        .cancel(cancel),
        .svc_withdraw(svc_withdraw), .svc_supply(svc_supply),
        .svc_product(svc_product), .svc_amount(svc_amount),
        .core(bus),
        .credit(credit), .change_valid(change_valid), .change_amount(change_amount),
        .coin_reject(coin_reject), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [19:0] bus_v;   // {mode, cm, cr, qr, pid, amt}
        int          at;
    } iss_t;
    typedef struct {
        logic [3:0] amt;
        int         at;
    } chg_t;

    iss_t exp_iss[$];
    chg_t exp_chg[$];

    // Model of the held core-bus data fields
    logic [3:0] m_cm = 0, m_qr = 0, m_amt = 0;
    logic [2:0] m_cr = 0, m_pid = 0;

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_iss(input logic [1:0] md, input int at);
        iss_t e;
        e.bus_v = {md, m_cm, m_cr, m_qr, m_pid, m_amt};
        e.at = at;
        exp_iss.push_back(e);
    endtask

    task automatic push_chg(input logic [3:0] a, input int at);
        chg_t e;
        e.amt = a;
        e.at = at;
        exp_chg.push_back(e);
    endtask

    task automatic coin(input logic [3:0] v);
        coin_in = 1'b1;
        coin_value = v;
        tick();
        coin_in = 1'b0;
    endtask

    task automatic set_core(input logic rl, input logic [3:0] money);
        bus.red_light = rl;
        bus.updated_customer_money = money;
    endtask

    // Customer selection that is expected to be accepted with the given credit
    task automatic buy(input logic [2:0] p, input logic [3:0] q, input logic [3:0] cr_now,
                       input logic [3:0] chg);
        m_cm = cr_now; m_cr = p; m_qr = q;
        push_iss(2'b00, cyc + 1);
        push_chg(chg, cyc + 2 + RL);
        sel_valid = 1'b1; sel_product = p; sel_qty = q;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("idle_timeout", busy, 0);
    endtask

    // Monitor: every bus issue and change pulse must match the head of its queue
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mode != 2'b11) begin
                if (exp_iss.size() == 0) begin
                    chk("unexpected_issue", int'(bus.mode), 3);
                end else begin
                    iss_t e;
                    e = exp_iss.pop_front();
                    chk("issue_bus", int'({bus.mode, bus.customer_money, bus.customer_request,
                        bus.quantity_request, bus.product_id, bus.amount_added}), int'(e.bus_v));
                    chk("issue_cycle", cyc, e.at);
                end
            end
            if (change_valid) begin
                if (exp_chg.size() == 0) begin
                    chk("unexpected_change", int'(change_valid), 0);
                end else begin
                    chg_t c;
                    c = exp_chg.pop_front();
                    chk("change_amount", int'(change_amount), int'(c.amt));
                    chk("change_cycle", cyc, c.at);
                end
            end
        end
    end

    initial begin
        set_core(1'b0, 4'd0);
        tick();
        tick();
        chk("rst_mode", int'(bus.mode), 3);
        chk("rst_credit", int'(credit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_change_valid", int'(change_valid), 0);
        chk("rst_cm", int'(bus.customer_money), 0);
        rst = 1'b0;
        tick();

        // Normal purchase: 4 + 2, product 7 qty 1, core returns 2
        coin(4'd4);
        coin(4'd2);
        chk("credit_6", int'(credit), 6);
        set_core(1'b0, 4'd2);
        buy(3'd7, 4'd1, 4'd6, 4'd2);
        chk("busy_issue", int'(busy), 1);
        wait_idle();
        chk("credit_after_buy", int'(credit), 0);
        chk("error_after_buy", int'(error), 0);

        // Core error with a coin rejected during WAIT: full refund of 14
        coin(4'd9);
        coin(4'd5);
        chk("credit_14", int'(credit), 14);
        set_core(1'b1, 4'd3);
        buy(3'd3, 4'd2, 4'd14, 4'd14);
        tick();                         // now in WAIT
        coin_in = 1'b1; coin_value = 4'd1;
        tick();
        coin_in = 1'b0;
        chk("coin_reject_wait", int'(coin_reject), 1);
        wait_idle();
        chk("error_core", int'(error), 1);
        chk("credit_after_refund", int'(credit), 0);

        // Next valid selection clears error; zero change still pulses
        coin(4'd3);
        set_core(1'b0, 4'd0);
        buy(3'd1, 4'd1, 4'd3, 4'd0);
        chk("error_cleared", int'(error), 0);
        wait_idle();
        chk("coin_reject_idle", int'(coin_reject), 0);

        // Saturation
        coin(4'd9);
        coin(4'd9);
        chk("credit_sat", int'(credit), 15);
        set_core(1'b0, 4'd5);
        buy(3'd2, 4'd1, 4'd15, 4'd5);
        wait_idle();

        // Cancel with credit 5
        coin(4'd5);
        chk("credit_5", int'(credit), 5);
        push_chg(4'd5, cyc + 1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("busy_cancel", int'(busy), 1);
        chk("credit_cancel", int'(credit), 0);
        tick();
        chk("busy_after_cancel", int'(busy), 0);

        // Selection at zero credit
        sel_valid = 1'b1; sel_product = 3'd2; sel_qty = 4'd1;
        tick();
        sel_valid = 1'b0;
        chk("error_empty_sel", int'(error), 1);
        chk("mode_empty_sel", int'(bus.mode), 3);
        chk("busy_empty_sel", int'(busy), 0);

        // Service supply product 1 amount 13
        m_pid = 3'd1; m_amt = 4'd13;
        push_iss(2'b10, cyc + 1);
        svc_supply = 1'b1; svc_product = 3'd1; svc_amount = 4'd13;
        tick();
        svc_supply = 1'b0;
        chk("error_supply_clear", int'(error), 0);
        wait_idle();

        // Withdraw and selection together: only withdraw issued
        coin(4'd4);
        push_iss(2'b01, cyc + 1);
        svc_withdraw = 1'b1; sel_valid = 1'b1; sel_product = 3'd5; sel_qty = 4'd2;
        tick();
        svc_withdraw = 1'b0; sel_valid = 1'b0;
        wait_idle();
        chk("credit_kept_wd", int'(credit), 4);

        // Withdraw with core error
        set_core(1'b1, 4'd0);
        push_iss(2'b01, cyc + 1);
        svc_withdraw = 1'b1;
        tick();
        svc_withdraw = 1'b0;
        wait_idle();
        chk("error_withdraw", int'(error), 1);

        // Reset during WAIT aborts the transaction
        set_core(1'b0, 4'd1);
        buy(3'd6, 4'd3, 4'd4, 4'd1);
        void'(exp_chg.pop_back());      // aborted: no change expected
        tick();                         // in WAIT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_cm = 0; m_cr = 0; m_qr = 0; m_pid = 0; m_amt = 0;
        chk("rst_mid_mode", int'(bus.mode), 3);
        chk("rst_mid_credit", int'(credit), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_change", int'(change_valid), 0);
        tick();
        tick();
        coin(4'd7);
        chk("credit_after_rst", int'(credit), 7);
        tick();

        chk("issue_queue_empty", exp_iss.size(), 0);
        chk("change_queue_empty", exp_chg.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
